// File: rtl/vga_pkg.sv
// Shared definitions for the character-mode VGA pipeline.
//   - Default geometry and VRAM parameters used by the readout blocks.
//   - Fetch phase encoding exported to the pixel generator.
//   - Span state encoding for the readout cell timer.
//   - Width helper for the per-character-row pixel counter.
package vga_pkg;

  localparam int DEF_ADDR_W     = 13;
  localparam int DEF_VRAM_WORDS = 8192;
  localparam int DEF_CHAR_H     = 16;
  localparam int DEF_CELL_CLKS  = 8;
  localparam int DEF_FETCHES    = 2;

  typedef enum logic {
    PHASE_CHAR = 1'b0,
    PHASE_ATTR = 1'b1
  } fetch_phase_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } span_state_e;

  // Width of vCount. A one-row font would give a zero-width counter,
  // so keep at least one bit.
  function automatic int vcnt_width(input int char_h);
    return (char_h > 1) ? $clog2(char_h) : 1;
  endfunction

endpackage

// File: rtl/readout_gen_if.sv
// Timing-generator <-> readout generator bundle.
//   master : sync/timing side, drives the timing strobes and scrollBase,
//            observes the readout address and fetch strobes.
//   slave  : readout_gen side.
// Signals:
//   vActive, hBeginActive, hEndActive, vCount, vSync, hBeginPulse,
//   scrollBase                 -> timing inputs to the readout generator
//   readoutAddr, fetchValid,
//   fetchPhase, active         -> readout outputs
interface readout_gen_if
  import vga_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int VCNT_W = vcnt_width(DEF_CHAR_H)
);

  logic              vActive;
  logic              hBeginActive;
  logic              hEndActive;
  logic [VCNT_W-1:0] vCount;
  logic              vSync;
  logic              hBeginPulse;
  logic [ADDR_W-1:0] scrollBase;

  logic [ADDR_W-1:0] readoutAddr;
  logic              fetchValid;
  logic              fetchPhase;
  logic              active;

  modport master (
    output vActive, hBeginActive, hEndActive, vCount, vSync, hBeginPulse,
           scrollBase,
    input  readoutAddr, fetchValid, fetchPhase, active
  );

  modport slave (
    input  vActive, hBeginActive, hEndActive, vCount, vSync, hBeginPulse,
           scrollBase,
    output readoutAddr, fetchValid, fetchPhase, active
  );

endinterface

// File: rtl/readout_cell_timer.sv
// Cell timer for the VRAM readout generator. Tracks whether a readout
// span is in progress and the clock position inside the current cell.
// Ports:
//   clk, nrst          : pixel clock, async active-low reset
//   v_sync             : frame restart, overrides everything else
//   v_active           : vertical active region (qualifies span start)
//   h_begin_active     : span start pulse (honoured only while idle)
//   h_end_active       : span end pulse (honoured only while active)
//   active             : span in progress
//   fetch_valid        : address is valid for this fetch slot
//   fetch_phase        : 0 = character fetch, 1 = attribute fetch
//   inc_stb            : advance the readout address on this edge
module readout_cell_timer
  import vga_pkg::*;
#(
  parameter int CELL_CLKS = DEF_CELL_CLKS,
  parameter int FETCHES   = DEF_FETCHES
) (
  input  logic clk,
  input  logic nrst,
  input  logic v_sync,
  input  logic v_active,
  input  logic h_begin_active,
  input  logic h_end_active,
  output logic active,
  output logic fetch_valid,
  output logic fetch_phase,
  output logic inc_stb
);

  localparam int SLOT   = CELL_CLKS / FETCHES;
  localparam int CNT_W  = $clog2(CELL_CLKS);
  localparam int SLOT_W = $clog2(SLOT);

  span_state_e       state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [SLOT_W-1:0] slot_pos;

  // SLOT is a power of two, so count % SLOT is just the low bits.
  assign slot_pos = count_q[SLOT_W-1:0];

  // NOTE: every variable gets a default at the top of the block so no
  // path leaves it unassigned; that is what keeps this from inferring latches.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (v_sync) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (h_begin_active && v_active) begin
            state_d = ST_ACTIVE;
            count_d = '0;
          end
        end
        ST_ACTIVE: begin
          if (h_end_active) begin
            state_d = ST_IDLE;
            count_d = '0;
          end else begin
            // Power-of-two cell length: natural wrap is modulo CELL_CLKS.
            count_d = count_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign active      = (state_q == ST_ACTIVE);
  assign fetch_valid = active & (slot_pos == SLOT_W'(1));
  // The increment at the last clock of a slot still fires when the span
  // ends on that same clock; only vSync suppresses it.
  assign inc_stb     = active & ~v_sync & (slot_pos == SLOT_W'(SLOT - 1));
  // With two fetches per cell the count MSB is count / SLOT.
  assign fetch_phase = (FETCHES == 2) ? count_q[CNT_W-1] : PHASE_CHAR;

endmodule

// File: rtl/readout_gen.sv
// VRAM readout address generator for the character-mode VGA pipeline.
// Emits one VRAM address per fetch slot between the timing generator and
// the VRAM read port, with per-frame scroll base, per-character-row
// repeat/advance and wrap-around at an arbitrary VRAM depth.
// Ports:
//   clk  : pixel clock
//   nrst : async active-low reset
//   bus  : readout_gen_if slave modport (timing inputs, readout outputs)
module readout_gen
  import vga_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int VRAM_WORDS = DEF_VRAM_WORDS,
  parameter int CHAR_H     = DEF_CHAR_H,
  parameter int CELL_CLKS  = DEF_CELL_CLKS,
  parameter int FETCHES    = DEF_FETCHES
) (
  input  logic           clk,
  input  logic           nrst,
  readout_gen_if.slave   bus
);

  localparam int VCNT_W = vcnt_width(CHAR_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VRAM_WORDS - 1);
  localparam logic [VCNT_W-1:0] LAST_ROW  = VCNT_W'(CHAR_H - 1);

  // Elaboration-time parameter legality.
  if (CELL_CLKS < 2 || (CELL_CLKS & (CELL_CLKS - 1)) != 0) begin : g_bad_cell_clks
    $error("readout_gen: CELL_CLKS must be a power of two");
  end
  if (FETCHES != 1 && FETCHES != 2) begin : g_bad_fetches
    $error("readout_gen: FETCHES must be 1 or 2");
  end
  if (CELL_CLKS / FETCHES < 2) begin : g_bad_slot
    $error("readout_gen: CELL_CLKS/FETCHES must be at least 2");
  end
  if (VRAM_WORDS < 2 || VRAM_WORDS > (2 ** ADDR_W)) begin : g_bad_vram
    $error("readout_gen: VRAM_WORDS must be in 2..2^ADDR_W");
  end

  logic              active;
  logic              fetch_valid;
  logic              fetch_phase;
  logic              inc_stb;
  logic [ADDR_W-1:0] readout_addr_q, readout_addr_d;
  logic [ADDR_W-1:0] row_begin_addr_q, row_begin_addr_d;
  logic [ADDR_W-1:0] readout_inc;

  readout_cell_timer #(
    .CELL_CLKS (CELL_CLKS),
    .FETCHES   (FETCHES)
  ) u_cell_timer (
    .clk            (clk),
    .nrst           (nrst),
    .v_sync         (bus.vSync),
    .v_active       (bus.vActive),
    .h_begin_active (bus.hBeginActive),
    .h_end_active   (bus.hEndActive),
    .active         (active),
    .fetch_valid    (fetch_valid),
    .fetch_phase    (fetch_phase),
    .inc_stb        (inc_stb)
  );

  // Wrap explicitly at the last VRAM word so non-power-of-two depths never
  // produce an out-of-range address.
  assign readout_inc = (readout_addr_q == LAST_ADDR) ? '0 : readout_addr_q + 1'b1;

  always_comb begin
    readout_addr_d   = readout_addr_q;
    row_begin_addr_d = row_begin_addr_q;
    if (bus.vSync) begin
      readout_addr_d   = bus.scrollBase;
      row_begin_addr_d = bus.scrollBase;
    end else if (!active) begin
      // Row bookkeeping happens in the horizontal blank: on the last pixel
      // row of a character row the current address becomes the start of
      // the next row; otherwise rewind to replay the same characters.
      if (bus.vActive && bus.hBeginPulse) begin
        if (bus.vCount == LAST_ROW) begin
          row_begin_addr_d = readout_addr_q;
        end else begin
          readout_addr_d = row_begin_addr_q;
        end
      end
    end else if (inc_stb) begin
      readout_addr_d = readout_inc;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      readout_addr_q   <= '0;
      row_begin_addr_q <= '0;
    end else begin
      readout_addr_q   <= readout_addr_d;
      row_begin_addr_q <= row_begin_addr_d;
    end
  end

  assign bus.readoutAddr = readout_addr_q;
  assign bus.fetchValid  = fetch_valid;
  assign bus.fetchPhase  = fetch_phase;
  assign bus.active      = active;

endmodule

// File: doc/readout_gen.md
# readout_gen

Parametrised VRAM readout address generator for the character-mode VGA pipeline. It sits between the sync/timing generator and the VRAM read port, and emits one address per fetch slot. It supports a configurable cell timing, one or two fetches per cell (character only, or character + attribute), a programmable per-frame scroll base and wrap-around at an arbitrary VRAM depth. It also exports fetch strobes and phase to the pixel generator.

## Interface
- ADDR_W, 13: VRAM address width.
- VRAM_WORDS, 8192: VRAM depth. Legal range is 2 to 2^ADDR_W; non-power-of-two is allowed.
- CHAR_H, 16: pixel rows per character row. `vCount` width is clog2(CHAR_H).
- CELL_CLKS, 8: clocks per character cell. Must be a power of two.
- FETCHES, 2: fetches per cell, 1 or 2. Defines SLOT = CELL_CLKS/FETCHES, which must be at least 2.
- `clk` in 1: pixel clock. One clock domain; all logic is on the rising edge.
- `nrst` in 1: reset, asynchronous, active-low.
- `vActive` in 1: vertical active region.
- `hBeginActive` in 1: one-cycle pulse at the start of the horizontal active region.
- `hEndActive` in 1: one-cycle pulse at the end of the horizontal active region.
- `vCount` in clog2(CHAR_H): pixel row within the current character row.
- `vSync` in 1: vertical sync, active-high.
- `hBeginPulse` in 1: one-cycle pulse at the start of the hsync pulse.
- `scrollBase` in ADDR_W: frame start address. Quasi-static; it only needs to be stable while `vSync` is high.
- `readoutAddr` out ADDR_W: VRAM read address, registered.
- `fetchValid` out 1: `readoutAddr` is valid for the current fetch slot.
- `fetchPhase` out 1: fetch type, 0 = character, 1 = attribute. Tied to 0 when FETCHES=1.
- `active` out 1: a readout span is in progress.

## Operation
- Registers:
  - `active`
  - `count` (clog2(CELL_CLKS) bits)
  - `rowBeginAddr` (ADDR_W)
  - `readoutAddr` (ADDR_W)
- Reset value of every register and output is 0.
- Reset is asynchronous. Asserting `nrst` mid-span clears state immediately, with no completion of the current span.
- The address increment is `inc(a) = (a == VRAM_WORDS-1) ? 0 : a+1`. It never produces a value at or above VRAM_WORDS.
- Priority order each cycle: reset, then vSync, then the IDLE/ACTIVE state behaviour.
- **vSync** (high on any cycle): `readoutAddr` and `rowBeginAddr` load `scrollBase`; `active` is cleared and `count` is set to 0. This overrides every other input.
- **IDLE** (`active` = 0):
  - `hBeginActive & vActive` sets `active` to 1 and `count` to 0.
  - `hEndActive` is ignored.
  - On `vActive & hBeginPulse`:
    - If `vCount == CHAR_H-1`, `rowBeginAddr` loads `readoutAddr`, which starts the next character row.
    - Otherwise `readoutAddr` loads `rowBeginAddr`, which repeats the current character row.
- **ACTIVE** (`active` = 1):
  - `count` advances by 1 per clock, modulo CELL_CLKS.
  - When `count % SLOT == SLOT-1`, `readoutAddr` loads `inc(readoutAddr)`.
  - `hEndActive` clears `active` and resets `count` to 0. The increment scheduled for the same cycle still happens.
  - `hBeginPulse` and `hBeginActive` are ignored.
- `fetchValid = active & (count % SLOT == 1)`.
- `fetchPhase = count / SLOT` when FETCHES=2, and 0 otherwise.
- Both are combinational decodes of registered state; they add no extra latency.

## Timing
- `readoutAddr` changes only on clock edges. It is stable from `count % SLOT == 0` through the end of the slot.
- With defaults, the first active cycle is count 0 at address A:
  - count 1: `fetchValid` with phase 0 (character), address A.
  - count 3: increment.
  - count 5: `fetchValid` with phase 1 (attribute), address A+1.
  - count 7: increment.
  - Next cell: count 0 at address A+2.
- Latency:
  - `hBeginActive` to `active`=1: one clock.
  - First `fetchValid`: two clocks after `hBeginActive`.
- A span of N cells advances `readoutAddr` by N·FETCHES.
- If `hBeginActive` and `hEndActive` arrive in the same IDLE cycle, the span starts.

## Structure
- Shared package `vga_pkg`:
  - default ADDR_W, VRAM_WORDS, CHAR_H, CELL_CLKS, FETCHES
  - phase constants PHASE_CHAR=0, PHASE_ATTR=1
- One sub-module, `readout_cell_timer`, holds `active` and `count`. It produces `fetchValid`, `fetchPhase` and the increment strobe.
- The top level holds the two address registers, the wrap incrementer and the vSync/row update logic.
- Parameter legality is checked at elaboration: CELL_CLKS a power of two, FETCHES in {1, 2}, SLOT ≥ 2, VRAM_WORDS ≤ 2^ADDR_W.

## Test plan
- **Frame load:** `scrollBase`=0x0100, pulse `vSync` → `readoutAddr`=`rowBeginAddr`=0x0100 and `active`=0.
- **One span:** defaults, start 0x0100, span of 80 cells:
  - `fetchValid` alternates phases 0 and 1 at 0x0100 and 0x0101.
  - `readoutAddr` is 0x01A0 after `hEndActive`.
- **Row repeat and advance:**
  - On scanlines with `vCount`=0..14, `hBeginPulse` restores 0x0100.
  - At `vCount`=15, `rowBeginAddr` becomes 0x01A0; the next scanline starts at 0x01A0.
- **Wrap:** VRAM_WORDS=6000, `scrollBase`=5999, 2-cell span → fetch addresses 5999, 0, 1, 2.
- **Single-fetch mode:** FETCHES=1, CELL_CLKS=8:
  - `fetchValid` at count 1 only, with `fetchPhase`=0.
  - Address +1 per cell, 4 cells → +4.
- **Collisions and reset:**
  - `vSync` during a span aborts it and loads `scrollBase`.
  - `hEndActive` at count 3 still increments.
  - `nrst` low mid-span zeroes all outputs within the same cycle.
